// File: rtl/maze_path_checker.sv
// Replays a solver's 2-bit move stream over a latched 16x16 map and flags legal arrival at (15,15).
// Optional revisit detection is enabled by defining MAZE_CHECK_REVISIT_EN.
module maze_path_checker #(
    parameter int MAX_STEPS = 255,
    parameter int STEP_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic [0:15][0:15]    Maze_Map,
    input  logic                 Move_Valid,
    input  logic [1:0]           Move,
    output logic                 Move_Ready,
    output logic                 Busy,
    output logic                 Pass,
    output logic                 Error,
    output logic [2:0]           Err_Code,
    output logic [3:0]           Row,
    output logic [3:0]           Col,
    output logic [STEP_W-1:0]    Step_Count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_WALK  = 3'd2;
    localparam logic [2:0] S_PASS  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BOUNDS  = 3'd1;
    localparam logic [2:0] ERR_WALL    = 3'd2;
    localparam logic [2:0] ERR_LIMIT   = 3'd3;
    localparam logic [2:0] ERR_REVISIT = 3'd4;
    localparam logic [2:0] ERR_BLOCKED = 3'd5;

    logic [2:0]           state;
    logic [0:15][0:15]    map_q;
    logic signed [4:0]    next_r;
    logic signed [4:0]    next_c;
    logic                 move_accept;
    logic                 at_limit;
    logic                 out_of_bounds;
    logic                 hits_wall;
    logic                 revisit;
    logic                 move_legal;
    logic                 at_goal;

    assign Move_Ready = (state == S_WALK);
    assign Busy       = (state == S_CHECK) || (state == S_WALK);

    // The candidate position lives in 5-bit signed space so that stepping off
    // either edge (-1 or 16) shows up as bit 4 being set.
    always_comb begin
        next_r = $signed({1'b0, Row});
        next_c = $signed({1'b0, Col});
        case (Move)
            2'b00:   next_c = $signed({1'b0, Col}) + 5'sd1;
            2'b01:   next_r = $signed({1'b0, Row}) - 5'sd1;
            2'b10:   next_c = $signed({1'b0, Col}) - 5'sd1;
            default: next_r = $signed({1'b0, Row}) + 5'sd1;
        endcase
    end

    assign move_accept   = Move_Valid && (state == S_WALK) && !Start;
    assign at_limit      = (Step_Count == STEP_W'(MAX_STEPS));
    assign out_of_bounds = next_r[4] | next_c[4];
    assign hits_wall     = map_q[next_r[3:0]][next_c[3:0]];
    assign at_goal       = (next_r[3:0] == 4'd15) && (next_c[3:0] == 4'd15);

`ifdef MAZE_CHECK_REVISIT_EN
    logic [0:15][0:15] visited_q;

    assign revisit = visited_q[next_r[3:0]][next_c[3:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            visited_q <= '0;
        end else if (Start) begin
            visited_q <= '0;
        end else if (state == S_CHECK) begin
            visited_q[0][0] <= 1'b1;
        end else if (move_legal) begin
            visited_q[next_r[3:0]][next_c[3:0]] <= 1'b1;
        end
    end
`else
    assign revisit = 1'b0;
`endif

    assign move_legal = move_accept && !at_limit && !out_of_bounds && !hits_wall && !revisit;

    // Start has priority in every state; an offending move is consumed but
    // leaves position and step count at their pre-move values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            map_q      <= '0;
            Pass       <= 1'b0;
            Error      <= 1'b0;
            Err_Code   <= ERR_NONE;
            Row        <= 4'd0;
            Col        <= 4'd0;
            Step_Count <= '0;
        end else if (Start) begin
            state      <= S_CHECK;
            map_q      <= Maze_Map;
            Pass       <= 1'b0;
            Error      <= 1'b0;
            Err_Code   <= ERR_NONE;
            Row        <= 4'd0;
            Col        <= 4'd0;
            Step_Count <= '0;
        end else begin
            case (state)
                S_CHECK: begin
                    if (map_q[0][0]) begin
                        state    <= S_ERROR;
                        Error    <= 1'b1;
                        Err_Code <= ERR_BLOCKED;
                    end else begin
                        state <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (move_accept) begin
                        if (at_limit) begin
                            state    <= S_ERROR;
                            Error    <= 1'b1;
                            Err_Code <= ERR_LIMIT;
                        end else if (out_of_bounds) begin
                            state    <= S_ERROR;
                            Error    <= 1'b1;
                            Err_Code <= ERR_BOUNDS;
                        end else if (hits_wall) begin
                            state    <= S_ERROR;
                            Error    <= 1'b1;
                            Err_Code <= ERR_WALL;
                        end else if (revisit) begin
                            state    <= S_ERROR;
                            Error    <= 1'b1;
                            Err_Code <= ERR_REVISIT;
                        end else begin
                            Row        <= next_r[3:0];
                            Col        <= next_c[3:0];
                            Step_Count <= Step_Count + STEP_W'(1);
                            if (at_goal) begin
                                state <= S_PASS;
                                Pass  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_path_checker.sv
// Directed bench for maze_path_checker: goal walk, bounds, wall, step limit/revisit, blocked start, reset.
// Expectations for the short-limit case follow MAZE_CHECK_REVISIT_EN when it is defined.
module tb_maze_path_checker;

   logic              clk;
   logic              rst;
   logic              start;
   logic [0:15][0:15] maze_map;
   logic              moveValid;
   logic [1:0]        move;

   logic       moveReady, busy, pass, error;
   logic [2:0] errCode;
   logic [3:0] row, col;
   logic [7:0] stepCount;

   logic       moveReady4, busy4, pass4, error4;
   logic [2:0] errCode4;
   logic [3:0] row4, col4;
   logic [7:0] stepCount4;

   int compared;
   int mismatched;

   maze_path_checker dut (
      .clk(clk), .rst(rst), .Start(start), .Maze_Map(maze_map),
      .Move_Valid(moveValid), .Move(move), .Move_Ready(moveReady), .Busy(busy),
      .Pass(pass), .Error(error), .Err_Code(errCode), .Row(row), .Col(col),
      .Step_Count(stepCount)
   );

   maze_path_checker #(.MAX_STEPS(4), .STEP_W(8)) dut4 (
      .clk(clk), .rst(rst), .Start(start), .Maze_Map(maze_map),
      .Move_Valid(moveValid), .Move(move), .Move_Ready(moveReady4), .Busy(busy4),
      .Pass(pass4), .Error(error4), .Err_Code(errCode4), .Row(row4), .Col(col4),
      .Step_Count(stepCount4)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:0] mv);
      moveValid = valid;
      move      = mv;
      stepCycle();
   endtask

   task automatic pulseStart();
      start = 1'b1;
      stepCycle();
      start = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ready"}, moveReady, 0);
      checkOutput({tag, "_busy"},  busy, 0);
      checkOutput({tag, "_pass"},  pass, 0);
      checkOutput({tag, "_error"}, error, 0);
      checkOutput({tag, "_code"},  errCode, 0);
      checkOutput({tag, "_row"},   row, 0);
      checkOutput({tag, "_col"},   col, 0);
      checkOutput({tag, "_steps"}, stepCount, 0);
   endtask

   // Directed scenarios with hand-computed expectations.
   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      start      = 1'b0;
      maze_map   = '0;
      moveValid  = 1'b0;
      move       = 2'b00;

      #2 rst = 1'b0;
      #1 checkAllZero("reset_async");
      stepCycle();
      stepCycle();
      rst = 1'b1;
      stepCycle();
      checkAllZero("idle");

      // Open map: 15 rights then 15 downs reaches the goal on the 30th accept.
      maze_map = '0;
      pulseStart();
      checkOutput("t1_check_busy", busy, 1);
      checkOutput("t1_check_ready", moveReady, 0);
      stepCycle();
      checkOutput("t1_walk_ready", moveReady, 1);
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b1, (i < 15) ? 2'b00 : 2'b11);
         if (i == 14) begin
            checkOutput("t1_mid_col", col, 15);
            checkOutput("t1_mid_row", row, 0);
         end
         if (i == 28) checkOutput("t1_pre_goal_pass", pass, 0);
      end
      moveValid = 1'b0;
      checkOutput("t1_pass", pass, 1);
      checkOutput("t1_error", error, 0);
      checkOutput("t1_steps", stepCount, 30);
      checkOutput("t1_row", row, 15);
      checkOutput("t1_col", col, 15);
      checkOutput("t1_ready", moveReady, 0);
      checkOutput("t1_busy", busy, 0);
      stepCycle();
      checkOutput("t1_pass_held", pass, 1);

      // Moving up from (0,0) leaves the map.
      pulseStart();
      checkOutput("t2_pass_cleared", pass, 0);
      stepCycle();
      applyStimulus(1'b1, 2'b01);
      moveValid = 1'b0;
      checkOutput("t2_error", error, 1);
      checkOutput("t2_code", errCode, 1);
      checkOutput("t2_row", row, 0);
      checkOutput("t2_col", col, 0);
      checkOutput("t2_steps", stepCount, 0);
      checkOutput("t2_ready", moveReady, 0);

      // Down to (1,0) is open, then right into the wall at (1,1).
      maze_map = '0;
      maze_map[0][1] = 1'b1;
      maze_map[1][1] = 1'b1;
      pulseStart();
      maze_map = '0;
      stepCycle();
      applyStimulus(1'b1, 2'b11);
      checkOutput("t3_row_after1", row, 1);
      checkOutput("t3_error_after1", error, 0);
      applyStimulus(1'b1, 2'b00);
      moveValid = 1'b0;
      checkOutput("t3_error", error, 1);
      checkOutput("t3_code", errCode, 2);
      checkOutput("t3_row", row, 1);
      checkOutput("t3_col", col, 0);
      checkOutput("t3_steps", stepCount, 1);

      // Back-and-forth on the short-limit instance.
      maze_map = '0;
      pulseStart();
      stepCycle();
      applyStimulus(1'b1, 2'b00);
      applyStimulus(1'b1, 2'b10);
      applyStimulus(1'b1, 2'b00);
      applyStimulus(1'b1, 2'b10);
      applyStimulus(1'b1, 2'b00);
      moveValid = 1'b0;
      checkOutput("t4_error", error4, 1);
`ifdef MAZE_CHECK_REVISIT_EN
      checkOutput("t4_code", errCode4, 4);
      checkOutput("t4_steps", stepCount4, 1);
      checkOutput("t4_col", col4, 1);
`else
      checkOutput("t4_code", errCode4, 3);
      checkOutput("t4_steps", stepCount4, 4);
      checkOutput("t4_col", col4, 0);
`endif

      // Blocked start cell.
      maze_map = '0;
      maze_map[0][0] = 1'b1;
      pulseStart();
      checkOutput("t5_check_ready", moveReady, 0);
      checkOutput("t5_check_error", error, 0);
      stepCycle();
      checkOutput("t5_error", error, 1);
      checkOutput("t5_code", errCode, 5);
      checkOutput("t5_ready", moveReady, 0);
      checkOutput("t5_busy", busy, 0);

      // Reset mid-walk, then restart.
      maze_map = '0;
      pulseStart();
      stepCycle();
      applyStimulus(1'b1, 2'b00);
      applyStimulus(1'b1, 2'b11);
      applyStimulus(1'b1, 2'b00);
      checkOutput("t6_row", row, 1);
      checkOutput("t6_col", col, 2);
      checkOutput("t6_steps", stepCount, 3);
      rst = 1'b0;
      #1 checkAllZero("t6_in_reset");
      stepCycle();
      rst = 1'b1;
      stepCycle();
      checkAllZero("t6_after_reset");
      moveValid = 1'b0;
      pulseStart();
      checkOutput("t6_start_row", row, 0);
      checkOutput("t6_start_steps", stepCount, 0);
      checkOutput("t6_start_busy", busy, 1);
      stepCycle();
      checkOutput("t6_ready", moveReady, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
